// File: rtl/uart_xfer_ctrl_if.sv
// rtl/uart_xfer_ctrl_if.sv - signal bundle between the UART transfer controller and the UART core
//
// Purpose: groups the Rx/Tx FIFO handshakes, the echo/manual controls and the
//          statistics outputs of uart_xfer_ctrl into one interface.
// Signals:
//   rx_empty, read_data   Rx FIFO empty flag and first-word-fall-through head byte
//   read_uart             Rx FIFO pop strobe
//   tx_full               Tx FIFO full flag
//   write_uart, write_data Tx FIFO push strobe and byte
//   echo_en               automatic echo enable
//   man_req, man_data     manual send request level and byte
//   man_ack               one-cycle pulse when the manual byte is pushed
//   busy                  controller is not idle
//   echo_cnt, man_cnt     statistics counters (CNT_W bits)
// Modports: master = controller side, slave = UART core / user side.
interface uart_xfer_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             rx_empty;
   logic [7:0]       read_data;
   logic             read_uart;
   logic             tx_full;
   logic             write_uart;
   logic [7:0]       write_data;
   logic             echo_en;
   logic             man_req;
   logic [7:0]       man_data;
   logic             man_ack;
   logic             busy;
   logic [CNT_W-1:0] echo_cnt;
   logic [CNT_W-1:0] man_cnt;

   modport master (
      input  rx_empty, read_data, tx_full, echo_en, man_req, man_data,
      output read_uart, write_uart, write_data, man_ack, busy, echo_cnt, man_cnt
   );

   modport slave (
      output rx_empty, read_data, tx_full, echo_en, man_req, man_data,
      input  read_uart, write_uart, write_data, man_ack, busy, echo_cnt, man_cnt
   );
endinterface

// File: rtl/uart_xfer_ctrl.sv
// rtl/uart_xfer_ctrl.sv - UART echo / manual-send transfer controller
//
// Purpose: moves bytes from the UART Rx FIFO back to the Tx FIFO (echo) and
//          pushes a manually requested byte, arbitrating the two round-robin.
// Ports:
//   clk_100MHz  single rising-edge clock
//   reset       synchronous active-high reset
//   bus         uart_xfer_ctrl_if.master (FIFO handshakes, controls, counters)
// Configuration:
//   UART_XFER_CTRL_STATS_EN  when defined, echo_cnt/man_cnt count echoed and
//                            manual bytes (wrapping); otherwise they read 0
//                            and no counter registers exist.
module uart_xfer_ctrl #(
   parameter int CNT_W = 8
) (
   input logic               clk_100MHz,
   input logic               reset,
   uart_xfer_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ECHO_POP = 2'd1,
      ECHO_WR  = 2'd2,
      MAN_WR   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] hold;
   logic [7:0] hold_nxt;
   logic       favor_man;       // 1: manual wins the next contention
   logic       favor_man_nxt;
   logic       echo_req;
   logic       grant_echo;
   logic       grant_man;
   logic       pop;
   logic       wr_cycle;
   logic       push;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state     <= IDLE;
         hold      <= 8'h00;
         favor_man <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold      <= hold_nxt;
         favor_man <= favor_man_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      hold_nxt      = hold;
      favor_man_nxt = favor_man;
      echo_req      = bus.echo_en & ~bus.rx_empty;
      grant_echo    = 1'b0;
      grant_man     = 1'b0;
      pop           = 1'b0;
      wr_cycle      = 1'b0;
      case (state)
         IDLE: begin
            // Echo wins unless manual is also asking and it is manual's turn.
            grant_echo = echo_req & (~bus.man_req | ~favor_man);
            grant_man  = bus.man_req & ~grant_echo;
            if (grant_echo) begin
               hold_nxt      = bus.read_data;
               favor_man_nxt = 1'b1;
               state_nxt     = ECHO_POP;
            end else if (grant_man) begin
               hold_nxt      = bus.man_data;
               favor_man_nxt = 1'b0;
               state_nxt     = MAN_WR;
            end
         end
         ECHO_POP: begin
            // Byte already captured from the fall-through head; just pop it.
            pop       = 1'b1;
            state_nxt = ECHO_WR;
         end
         ECHO_WR, MAN_WR: begin
            wr_cycle = 1'b1;
            if (!bus.tx_full) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are masked while reset is high so an interrupted transfer never
   // touches the FIFOs in the reset cycle itself.
   assign push           = wr_cycle & ~bus.tx_full & ~reset;
   assign bus.read_uart  = pop & ~reset;
   assign bus.write_uart = push;
   assign bus.write_data = hold;
   assign bus.man_ack    = push & (state == MAN_WR);
   assign bus.busy       = (state != IDLE);

`ifdef UART_XFER_CTRL_STATS_EN
   logic [CNT_W-1:0] echo_q;
   logic [CNT_W-1:0] man_q;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         echo_q <= '0;
         man_q  <= '0;
      end else begin
         if (push && (state == ECHO_WR)) begin
            echo_q <= echo_q + CNT_W'(1);
         end
         if (push && (state == MAN_WR)) begin
            man_q <= man_q + CNT_W'(1);
         end
      end
   end

   assign bus.echo_cnt = echo_q;
   assign bus.man_cnt  = man_q;
`else
   assign bus.echo_cnt = {CNT_W{1'b0}};
   assign bus.man_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/uart_xfer_ctrl.md
UART_XFER_CTRL -- requirements
Module: uart_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the statistics counters.
REQ-002 The block SHALL have port clk_100MHz, input, 1 bit: the single clock, rising-edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port rx_empty, input, 1 bit: the Rx FIFO empty flag from the UART core.
REQ-005 The block SHALL have port read_data, input, 8 bits: the Rx FIFO head byte, first-word-fall-through, valid while rx_empty is low.
REQ-006 The block SHALL have port read_uart, output, 1 bit: the Rx FIFO pop strobe.
REQ-007 The block SHALL have port tx_full, input, 1 bit: the Tx FIFO full flag from the UART core.
REQ-008 The block SHALL have port write_uart, output, 1 bit: the Tx FIFO push strobe.
REQ-009 The block SHALL have port write_data, output, 8 bits: the byte pushed to the Tx FIFO.
REQ-010 The block SHALL have port echo_en, input, 1 bit: enables automatic echo of received bytes.
REQ-011 The block SHALL have port man_req, input, 1 bit: manual-send request, a level held until man_ack.
REQ-012 The block SHALL have port man_data, input, 8 bits: the manual byte, for example from the switches.
REQ-013 The block SHALL have port man_ack, output, 1 bit: a one-cycle pulse when the manual byte is pushed.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have ports echo_cnt and man_cnt, each output, CNT_W bits: the count of echoed bytes and the count of manual bytes.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, ECHO_POP, ECHO_WR and MAN_WR.
REQ-017 The IDLE state SHALL compute two requests:
- echo request = echo_en and not rx_empty;
- manual request = man_req.
REQ-018 When both requests are present in IDLE, the block SHALL grant round-robin: the requester not granted last wins, and echo wins first after reset.
REQ-019 On an echo grant, the block SHALL latch read_data into the hold register and transition to ECHO_POP.
REQ-020 On a manual grant, the block SHALL latch man_data into the hold register and transition to MAN_WR.
REQ-021 In ECHO_POP, read_uart SHALL be high for exactly that one cycle, and the next state SHALL be ECHO_WR.
REQ-022 In ECHO_WR and MAN_WR, write_uart SHALL equal not tx_full.
REQ-023 In any write cycle, write_data SHALL equal the hold register.
REQ-024 In ECHO_WR and MAN_WR, the block SHALL return to IDLE on the cycle write_uart is high, and SHALL otherwise stay and wait indefinitely.
REQ-025 In MAN_WR, man_ack SHALL be high on the same cycle as write_uart, and only then.
REQ-026 Echo latency SHALL be fixed as follows, counting cycle 0 as IDLE with the request seen:
- read_uart high in cycle 1;
- write_uart high in cycle 2 if tx_full is low;
- back in IDLE in cycle 3.
REQ-027 Manual latency SHALL be: grant in cycle 0, write_uart and man_ack in cycle 1 if tx_full is low.
REQ-028 read_uart and write_uart SHALL never be high in the same cycle.
REQ-029 Each pulse SHALL pop or push at most one byte.
REQ-030 If echo_en falls in ECHO_POP or ECHO_WR, the block SHALL still complete the write, because the popped byte is never dropped.
REQ-031 If man_req falls in MAN_WR before the push, the block SHALL still push the latched byte and pulse man_ack.
REQ-032 The block SHALL take no new grant in the cycle it returns to IDLE, so there is a minimum 1 IDLE cycle between transfers.
REQ-033 The block SHALL issue no read_uart while rx_empty is high; the grant condition guarantees this.

Reset
REQ-034 Reset SHALL be synchronous and active-high, and SHALL take priority over all FSM activity, including mid-transfer.
REQ-035 In the cycle after reset is sampled high, the block SHALL have:
- state IDLE;
- read_uart, write_uart, man_ack and busy all 0;
- write_data 0 and the hold register 0;
- the round-robin pointer favouring echo;
- echo_cnt and man_cnt both 0.
REQ-036 A reset asserted in ECHO_WR SHALL discard the held byte with no write, and this loss SHALL be accepted.

Configuration
REQ-037 The macro UART_XFER_CTRL_STATS_EN SHALL control the statistics counters.
REQ-038 With UART_XFER_CTRL_STATS_EN defined:
- echo_cnt SHALL increment on each echo write_uart;
- man_cnt SHALL increment on each man_ack;
- both counters SHALL wrap modulo 2^CNT_W with no saturation.
REQ-039 Without UART_XFER_CTRL_STATS_EN, echo_cnt and man_cnt SHALL be constant 0, no counter registers SHALL be implemented, and the ports SHALL remain present.

Verification
REQ-040 Scenario, echo: with echo_en=1, tx_full=0 and read_data=8'h41, drop rx_empty for 1 cycle -> read_uart at +1, write_uart with write_data=8'h41 at +2, echo_cnt=1.
REQ-041 Scenario, backpressure: with tx_full=1 held for 5 cycles during ECHO_WR -> write_uart stays low and busy stays high, then exactly one write_uart with the held byte after tx_full falls.
REQ-042 Scenario, round-robin: man_req=1 with man_data=8'h5A and echo pending continuously -> writes alternate echo, 8'h5A, echo, 8'h5A, and man_ack pulses once per 8'h5A write.
REQ-043 Scenario, reset mid-operation: reset in ECHO_WR -> next cycle state IDLE, no write_uart, counters 0, and the next contention grants echo.
REQ-044 Scenario, counter wrap: with CNT_W=4 and the macro defined, 17 manual sends -> man_cnt=1; with the macro undefined -> man_cnt=0 throughout.
